// File: rtl/header_insert.sv
// header_insert: transmit framer emitting PAIRS preamble pairs,
// then a length-announced payload, then GAP idle bytes.
module header_insert #(
  parameter int unsigned PAIRS     = 5,
  parameter logic [7:0]  HDR_A     = 8'h55,
  parameter logic [7:0]  HDR_B     = 8'hD5,
  parameter logic [7:0]  IDLE_BYTE = 8'h00,
  parameter int unsigned GAP       = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] dout_o,
  output logic       dout_vld_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_GAPS = 2'd3;

  // Index of the final HDR_B and of the final gap edge.
  localparam logic [4:0] HDR_LAST = 5'(2 * PAIRS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [4:0] hidx_q, hidx_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [7:0] dout_q, dout_d;
  logic       vld_q, vld_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] pcnt_nxt;

  // Next-state and next-output logic; outputs default to idle.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hidx_d   = hidx_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    dout_d   = IDLE_BYTE;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pcnt_nxt = pcnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != 8'd0) begin
            state_d = S_HDR;
            len_d   = len_i;
            hidx_d  = 5'd1;
            pcnt_d  = 8'd0;
            gcnt_d  = 4'd0;
            dout_d  = HDR_A;
            vld_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        dout_d = hidx_q[0] ? HDR_B : HDR_A;
        vld_d  = 1'b1;
        if (hidx_q == HDR_LAST) begin
          state_d = S_PAY;
          hidx_d  = 5'd0;
        end else begin
          hidx_d = hidx_q + 5'd1;
        end
      end
      S_PAY: begin
        // s_ready is high throughout PAY, so s_valid alone is the handshake.
        if (s_valid_i) begin
          dout_d = s_data_i;
          vld_d  = 1'b1;
          pcnt_d = pcnt_nxt;
          if (pcnt_nxt == len_q) begin
            state_d = S_GAPS;
            gcnt_d  = 4'd0;
          end
        end
      end
      S_GAPS: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          gcnt_d  = 4'd0;
          done_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      hidx_q  <= 5'd0;
      pcnt_q  <= 8'd0;
      gcnt_q  <= 4'd0;
      dout_q  <= IDLE_BYTE;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hidx_q  <= hidx_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready_o  = (state_q == S_PAY);
  assign busy_o     = (state_q != S_IDLE);
  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_header_insert.sv
// tb_header_insert: scoreboard bench for header_insert with a
// byte-sequence reference model and randomized payload stalls.
module tb_header_insert;

  localparam int P = 5;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // DUT a: default parameters
  logic       rst_a = 1'b1, start_a = 1'b0, sv_a = 1'b0;
  logic [7:0] len_a = 8'd0, sd_a = 8'd0;
  logic       rdy_a, vld_a, busy_a, done_a, err_a;
  logic [7:0] dout_a;

  header_insert u_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .len_i(len_a),
    .s_data_i(sd_a), .s_valid_i(sv_a), .s_ready_o(rdy_a),
    .dout_o(dout_a), .dout_vld_o(vld_a), .busy_o(busy_a),
    .done_o(done_a), .err_o(err_a)
  );

  // DUT b: parameter sweep
  logic       rst_b = 1'b1, start_b = 1'b0, sv_b = 1'b0;
  logic [7:0] len_b = 8'd0, sd_b = 8'd0;
  logic       rdy_b, vld_b, busy_b, done_b, err_b;
  logic [7:0] dout_b;

  header_insert #(
    .PAIRS(2), .HDR_A(8'h56), .HDR_B(8'hD6),
    .IDLE_BYTE(8'h00), .GAP(1)
  ) u_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .len_i(len_b),
    .s_data_i(sd_b), .s_valid_i(sv_b), .s_ready_o(rdy_b),
    .dout_o(dout_b), .dout_vld_o(vld_b), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_a[$], pay_a[$], stg[$];
  int         dly_a[$], stgd[$];
  logic [7:0] exp_b[$], pay_b[$];
  int wait_a = 0;
  int done_a_n = 0, err_a_n = 0, done_b_n = 0;
  bit rdy_seen_a = 1'b0;
  int fv_a = -1;
  int t0 = 0, exp_len = 0, d_cyc = 0;

  // payload source a: optional idle cycles after each accepted byte
  initial forever begin
    @(negedge clk);
    if (pay_a.size() == 0) sv_a = 1'b0;
    else if (wait_a > 0) begin
      sv_a = 1'b0;
      wait_a--;
    end else begin
      sv_a = 1'b1;
      sd_a = pay_a[0];
    end
    #1;
    if (sv_a && rdy_a && pay_a.size() > 0) begin
      void'(pay_a.pop_front());
      wait_a = (dly_a.size() > 0) ? dly_a.pop_front() : 0;
    end
  end

  // payload source b: always valid
  initial forever begin
    @(negedge clk);
    if (pay_b.size() > 0) begin
      sv_b = 1'b1;
      sd_b = pay_b[0];
    end else sv_b = 1'b0;
    #1;
    if (sv_b && rdy_b && pay_b.size() > 0) void'(pay_b.pop_front());
  end

  // monitor a
  initial forever begin
    @(negedge clk);
    if (vld_a) begin
      if (fv_a < 0) fv_a = cyc;
      if (exp_a.size() == 0) chk("a_unexpected_vld", 1, 0);
      else chk("a_dout", int'(dout_a), int'(exp_a.pop_front()));
    end else chk("a_idle_dout", int'(dout_a), 0);
    if (done_a) done_a_n++;
    if (err_a) err_a_n++;
    if (rdy_a) rdy_seen_a = 1'b1;
  end

  // monitor b
  initial forever begin
    @(negedge clk);
    if (vld_b) begin
      if (exp_b.size() == 0) chk("b_unexpected_vld", 1, 0);
      else chk("b_dout", int'(dout_b), int'(exp_b.pop_front()));
    end else chk("b_idle_dout", int'(dout_b), 0);
    if (done_b) done_b_n++;
  end

  // queue one frame on a; called just after a negedge, returns at cycle 1
  task automatic frame_a(input int n, input int maxd);
    int bub = 0;
    for (int i = 0; i < P; i++) begin
      exp_a.push_back(8'h55);
      exp_a.push_back(8'hD5);
    end
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      int d;
      b = (i < stg.size()) ? stg[i] : 8'($urandom);
      d = (i < stgd.size()) ? stgd[i] : int'($urandom_range(maxd, 0));
      if (i == n - 1) d = 0;
      bub += d;
      exp_a.push_back(b);
      pay_a.push_back(b);
      dly_a.push_back(d);
    end
    stg.delete();
    stgd.delete();
    exp_len = 2 * P + n + G + bub;
    fv_a = -1;
    rdy_seen_a = 1'b0;
    start_a = 1'b1;
    len_a = 8'(n);
    @(negedge clk);
    start_a = 1'b0;
    len_a = 8'($urandom);
    t0 = cyc;
  endtask

  task automatic wait_done_a(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_a && k < 3000);
    if (!done_a) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk(nm, cyc - t0 + 1, exp_len);
      chk({nm, "_busy"}, int'(busy_a), 0);
    end
    d_cyc = cyc;
  endtask

  initial begin
    int nd = 0;
    int tb = 0;
    int d1 = 0;
    int k = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_ready", int'(rdy_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_b_vld", int'(vld_b), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // basic frame then back-to-back frame in the done cycle
    stg = '{8'h11, 8'h22, 8'h33, 8'h44};
    stgd = '{0, 0, 0, 0};
    frame_a(4, 0);
    tb = t0;
    wait_done_a("basic_done");
    nd++;
    chk("basic_first_hdr", fv_a - tb, 0);
    d1 = d_cyc;
    frame_a(2, 0);
    wait_done_a("b2b_done");
    nd++;
    chk("b2b_first_hdr", fv_a - d1, 1);
    chk("b2b_done_abs", d_cyc - tb + 1, 30);
    repeat (3) @(negedge clk);

    // two bubbles after the first payload byte
    stg = '{8'h11, 8'h22, 8'h33};
    stgd = '{2, 0, 0};
    frame_a(3, 0);
    wait_done_a("bubble_done");
    nd++;
    repeat (2) @(negedge clk);

    // zero-length start
    start_a = 1'b1;
    len_a = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    chk("err_pulse", int'(err_a), 1);
    chk("err_busy", int'(busy_a), 0);
    chk("err_dout", int'(dout_a), 0);
    @(negedge clk);
    chk("err_one_cycle", int'(err_a), 0);
    chk("err_busy2", int'(busy_a), 0);

    // start pulsed during HDR and during GAPS is ignored
    frame_a(3, 0);
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    len_a = 8'd5;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("ign_busy_gaps", int'(busy_a), 1);
    start_a = 1'b1;
    len_a = 8'd7;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("ign_done");
    nd++;
    repeat (20) @(negedge clk);
    chk("ign_single_frame", exp_a.size(), 0);

    // reset while header byte 6 is on dout
    frame_a(4, 0);
    repeat (5) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    exp_a.delete();
    pay_a.delete();
    dly_a.delete();
    wait_a = 0;
    chk("rstmid_dout", int'(dout_a), 0);
    chk("rstmid_vld", int'(vld_a), 0);
    chk("rstmid_ready", int'(rdy_a), 0);
    chk("rstmid_busy", int'(busy_a), 0);
    chk("rstmid_done", int'(done_a), 0);
    k = done_a_n;
    repeat (30) @(negedge clk);
    chk("rstmid_no_ready", int'(rdy_seen_a), 0);
    chk("rstmid_no_done", done_a_n, k);
    frame_a(3, 0);
    wait_done_a("rstmid_new_done");
    nd++;

    // randomized frames with random bubbles
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      frame_a(int'($urandom_range(24, 1)), 2);
      wait_done_a("rand_done");
      nd++;
    end
    repeat (5) @(negedge clk);
    chk("a_done_count", done_a_n, nd);
    chk("a_err_count", err_a_n, 1);
    chk("a_exp_empty", exp_a.size(), 0);

    // sweep: PAIRS=2, GAP=1, len=255
    for (int i = 0; i < 2; i++) begin
      exp_b.push_back(8'h56);
      exp_b.push_back(8'hD6);
    end
    for (int i = 0; i < 255; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_b.push_back(b);
      pay_b.push_back(b);
    end
    start_b = 1'b1;
    len_b = 8'd255;
    @(negedge clk);
    start_b = 1'b0;
    len_b = 8'd0;
    tb = cyc;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_b && k < 1000);
    if (!done_b) chk("sweep_timeout", 0, 1);
    else chk("sweep_done", cyc - tb + 1, 260);
    repeat (5) @(negedge clk);
    chk("sweep_exp_empty", exp_b.size(), 0);
    chk("sweep_pay_empty", pay_b.size(), 0);
    chk("sweep_done_count", done_b_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/header_insert.md
# header_insert

Transmit-side framer sitting directly upstream of `header_detect`. Takes a length-announced payload from a valid/ready byte source and emits one continuous byte-per-cycle stream: PAIRS repetitions of the HDR_A/HDR_B preamble pair, then the payload bytes, then GAP idle bytes. The output is shaped so `header_detect` sees exactly PAIRS consecutive pairs per frame. Used as its stimulus source and on the transmit path.

## Interface
- `PAIRS`, 5: number of HDR_A/HDR_B pairs per frame (1..15).
- `HDR_A`, 8'h55: first preamble byte of each pair.
- `HDR_B`, 8'hD5: second preamble byte of each pair.
- `IDLE_BYTE`, 8'h00: value driven on `dout` whenever no frame byte is presented.
- `GAP`, 2: idle cycles inserted after the last payload byte (1..15).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request, sampled only in IDLE.
- `len` in 8: payload byte count, latched with `start`; 0 is illegal.
- `s_data` in 8: payload byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: payload accepted on an edge where `s_valid && s_ready`.
- `dout` out 8: registered output byte stream; connects to `header_detect.din`.
- `dout_vld` out 1: registered; high when `dout` carries a header or payload byte.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when the frame completes.
- `err` out 1: one-cycle pulse when `start` arrives with `len == 0`.

## Operation
- States: IDLE, HDR, PAY, GAPS. `s_ready = (state == PAY)`, combinational from state only.
- **IDLE**
  - `dout = IDLE_BYTE`, `dout_vld = 0`.
  - `start && len != 0`: latch `len`; go to HDR; on the same edge register `dout <= HDR_A`, `dout_vld <= 1`, header index = 1.
  - `start && len == 0`: `err` pulse next cycle; stay in IDLE.
- **HDR**
  - Each edge emits the next preamble byte: even index = HDR_A, odd index = HDR_B.
  - The edge that emits index 2*PAIRS-1 (the final HDR_B) also moves to PAY.
- **PAY**
  - Handshake edge: `dout <= s_data`, `dout_vld <= 1`, payload counter +1.
  - No handshake: `dout <= IDLE_BYTE`, `dout_vld <= 0` (bubble). Bubbles are legal and do not abort the frame.
  - The edge accepting byte number `len` moves to GAPS, gap counter = 0.
- **GAPS**
  - Each edge drives `dout <= IDLE_BYTE`, `dout_vld <= 0`.
  - After GAP edges in GAPS, go to IDLE and register `done <= 1` for one cycle.
- `start` while busy is ignored, not queued. `len` changes after latching are ignored.
- Counters:
  - header index is 5 bits;
  - payload counter is 8 bits and compares against latched `len`, so 255 works without wrap;
  - gap counter is 4 bits.
- Reset values: state IDLE, `dout = IDLE_BYTE`, `dout_vld = 0`, `s_ready = 0`, `busy = 0`, `done = 0`, `err = 0`, all counters 0.
- Reset mid-frame: aborts on that edge. No further bytes are accepted and no `done` is produced.

## Timing
Cycle k is the cycle after edge E(k-1). `start` is sampled at E0, `s_valid` is held high, P = PAIRS.
- Preamble on `dout` in cycles 1..2P. First HDR_A appears 1 cycle after the start edge.
- `s_ready` is high from cycle 2P through cycle 2P+len-1, so there is no bubble between the last HDR_B and the first payload byte.
- Payload on `dout` in cycles 2P+1..2P+len.
- Idle bytes from cycle 2P+len+1.
- `busy` is high in cycles 1..2P+len+GAP-1.
- `done` and `busy` low coincide in cycle 2P+len+GAP.
- A `start` in the `done` cycle is accepted. Its HDR_A appears in cycle 2P+len+GAP+1, so back-to-back frames are separated by exactly GAP idle bytes.
- Each payload bubble delays every later event by one cycle.

## Test plan
- **Basic frame:** defaults, `len=4`, payload 11,22,33,44 with `s_valid` held, `start` at E0 -> `dout` = 55,D5 ×5 in cycles 1–10, then 11,22,33,44 in cycles 11–14, 00 in cycles 15–16; `done` in cycle 16. `header_detect` pair counter reaches 4.
- **Back-to-back:** second `start` (`len=2`) in the `done` cycle -> next 55 in cycle 17; exactly 2 idle bytes between frames; second `done` in cycle 30.
- **Bubbles:** `len=3`, `s_valid` low for 2 cycles after the first payload byte -> `dout` 11,00,00,22,33 with `dout_vld` 1,0,0,1,1; `done` 2 cycles later than with no stall.
- **Illegal/ignored start:** `start` with `len=0` -> `err` pulse 1 cycle, `busy` stays 0, `dout` stays 00. `start` pulsed during HDR and GAPS -> ignored, only one frame emitted.
- **Reset mid-frame:** `rst` high for 1 cycle while emitting header byte 6 -> all outputs at reset values next cycle, `s_ready` never asserted, no `done`. A new `start` then produces a full 10-byte preamble.
- **Parameter sweep:** PAIRS=2, GAP=1, HDR_A=56, HDR_B=D6, `len=255` -> 56,D6,56,D6, then 255 payload bytes with the counter not wrapping, 1 idle byte, `done`.
